// File: rtl/unidad_busqueda.sv
// ============================================================================
// Module   : unidad_busqueda
// Function : instruction-fetch front end; owns the PC, requests instruction
//            memory and hands one instruction at a time to decode.
//            Optional macro FETCH_ALIGN_CHECK_EN: word-aligns redirect
//            targets and raises a sticky err_alineacion flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module unidad_busqueda #(
    parameter int               ANCHO    = 64,
    parameter logic [ANCHO-1:0] PC_RESET = '0,
    parameter int               PASO     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             salto_valido,
    input  logic [ANCHO-1:0] direccion_salto,
    output logic             im_req,
    output logic [ANCHO-1:0] im_dir,
    input  logic             im_ack,
    input  logic [31:0]      im_dato,
    output logic             instr_valida,
    output logic [31:0]      instr,
    output logic [ANCHO-1:0] instr_pc,
    input  logic             instr_listo,
    output logic [ANCHO-1:0] bus_direccion_im,
    output logic             err_alineacion
);

    localparam logic [ANCHO-1:0] c_paso = ANCHO'(PASO);

    typedef enum logic [1:0] {
        INICIO   = 2'd0,
        PEDIR    = 2'd1,
        ENTREGAR = 2'd2
    } estado_t;

    estado_t          r_estado, w_estado_sig;
    logic [ANCHO-1:0] r_pc, w_pc_sig;
    logic             r_descartar, w_descartar_sig;
    logic [31:0]      r_instr, w_instr_sig;
    logic [ANCHO-1:0] r_instr_pc, w_instr_pc_sig;
    logic             r_instr_valida, w_instr_valida_sig;
    logic [ANCHO-1:0] w_objetivo;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_err;

    assign w_objetivo = {direccion_salto[ANCHO-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (salto_valido && (direccion_salto[1:0] != 2'b00)) begin
            r_err <= 1'b1;
        end
    end

    assign err_alineacion = r_err;
`else
    assign w_objetivo     = direccion_salto;
    assign err_alineacion = 1'b0;
`endif

    always_comb begin
        w_estado_sig       = r_estado;
        w_pc_sig           = r_pc;
        w_descartar_sig    = r_descartar;
        w_instr_sig        = r_instr;
        w_instr_pc_sig     = r_instr_pc;
        w_instr_valida_sig = r_instr_valida;

        case (r_estado)
            INICIO: begin
                w_estado_sig = PEDIR;
                if (salto_valido) begin
                    w_pc_sig = w_objetivo;
                end
            end

            PEDIR: begin
                if (im_ack) begin
                    // A response owed to a redirected request is consumed and dropped
                    if (salto_valido || r_descartar) begin
                        w_descartar_sig = 1'b0;
                    end else begin
                        w_instr_sig        = im_dato;
                        w_instr_pc_sig     = r_pc;
                        w_instr_valida_sig = 1'b1;
                        w_pc_sig           = r_pc + c_paso;
                        w_estado_sig       = ENTREGAR;
                    end
                end else if (salto_valido) begin
                    w_descartar_sig = 1'b1;
                end
                if (salto_valido) begin
                    w_pc_sig = w_objetivo;
                end
            end

            ENTREGAR: begin
                // Redirect wins over a simultaneous accept
                if (salto_valido) begin
                    w_pc_sig           = w_objetivo;
                    w_instr_valida_sig = 1'b0;
                    w_estado_sig       = PEDIR;
                end else if (instr_listo) begin
                    w_instr_valida_sig = 1'b0;
                    w_estado_sig       = PEDIR;
                end
            end

            default: begin
                w_estado_sig = INICIO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado       <= INICIO;
            r_pc           <= PC_RESET;
            r_descartar    <= 1'b0;
            r_instr        <= '0;
            r_instr_pc     <= '0;
            r_instr_valida <= 1'b0;
        end else begin
            r_estado       <= w_estado_sig;
            r_pc           <= w_pc_sig;
            r_descartar    <= w_descartar_sig;
            r_instr        <= w_instr_sig;
            r_instr_pc     <= w_instr_pc_sig;
            r_instr_valida <= w_instr_valida_sig;
        end
    end

    assign im_req           = (r_estado == PEDIR);
    assign im_dir           = r_pc;
    assign instr_valida     = r_instr_valida;
    assign instr            = r_instr;
    assign instr_pc         = r_instr_pc;
    assign bus_direccion_im = r_instr_pc;

endmodule

`default_nettype wire

// File: tb/tb_unidad_busqueda.sv
// ============================================================================
// Module   : tb_unidad_busqueda
// Function : self-checking bench for unidad_busqueda (two instances with
//            different reset PCs), directed scenarios plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unidad_busqueda;

    localparam logic [63:0] c_pc_alto = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        salto_valido;
    logic [63:0] direccion_salto;
    logic        im_ack;
    logic [31:0] im_dato;
    logic        instr_listo;

    logic        im_req0, im_req1, val0, val1, err0, err1;
    logic [63:0] im_dir0, im_dir1, ipc0, ipc1, bus0, bus1;
    logic [31:0] instr0, instr1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    unidad_busqueda u_dut0 (
        .clk(clk), .rst_n(rst_n), .salto_valido(salto_valido),
        .direccion_salto(direccion_salto), .im_req(im_req0), .im_dir(im_dir0),
        .im_ack(im_ack), .im_dato(im_dato), .instr_valida(val0), .instr(instr0),
        .instr_pc(ipc0), .instr_listo(instr_listo), .bus_direccion_im(bus0),
        .err_alineacion(err0)
    );

    unidad_busqueda #(.PC_RESET(c_pc_alto)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .salto_valido(salto_valido),
        .direccion_salto(direccion_salto), .im_req(im_req1), .im_dir(im_dir1),
        .im_ack(im_ack), .im_dato(im_dato), .instr_valida(val1), .instr(instr1),
        .instr_pc(ipc1), .instr_listo(instr_listo), .bus_direccion_im(bus1),
        .err_alineacion(err1)
    );

    // Transaction-level reference: "arrancado" = out of the post-reset idle
    // cycle, "tiene" = holding an instruction for decode, "deuda" = one
    // response still owed to a request that was redirected.
    logic [63:0] m_pc    [2];
    bit          m_arr   [2];
    bit          m_tiene [2];
    bit          m_deuda [2];
    bit          m_err   [2];
    logic [31:0] m_instr [2];
    logic [63:0] m_ipc   [2];

    function automatic logic [63:0] destino(input logic [63:0] d);
`ifdef FETCH_ALIGN_CHECK_EN
        return d & ~64'h3;
`else
        return d;
`endif
    endfunction

    function automatic bit desalineado(input logic [63:0] d);
`ifdef FETCH_ALIGN_CHECK_EN
        return d[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelo();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_pc[k]    = (k == 0) ? 64'h0 : c_pc_alto;
                m_arr[k]   = 0;
                m_tiene[k] = 0;
                m_deuda[k] = 0;
                m_err[k]   = 0;
                m_instr[k] = '0;
                m_ipc[k]   = '0;
            end else begin
                if (salto_valido && desalineado(direccion_salto)) m_err[k] = 1;
                if (!m_arr[k]) begin
                    m_arr[k] = 1;
                end else if (m_tiene[k]) begin
                    if (salto_valido || instr_listo) m_tiene[k] = 0;
                end else if (im_ack) begin
                    if (salto_valido || m_deuda[k]) begin
                        m_deuda[k] = 0;
                    end else begin
                        m_instr[k] = im_dato;
                        m_ipc[k]   = m_pc[k];
                        m_tiene[k] = 1;
                        m_pc[k]    = m_pc[k] + 64'd4;
                    end
                end else if (salto_valido) begin
                    m_deuda[k] = 1;
                end
                if (salto_valido) m_pc[k] = destino(direccion_salto);
            end
        end
    endtask

    task automatic chk(input string nombre, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nombre, act, exp, $time);
        end
    endtask

    task automatic comparar();
        chk("req0",   {63'd0, im_req0}, {63'd0, m_arr[0] && !m_tiene[0]});
        chk("dir0",   im_dir0,          m_pc[0]);
        chk("val0",   {63'd0, val0},    {63'd0, m_tiene[0]});
        chk("instr0", {32'd0, instr0},  {32'd0, m_instr[0]});
        chk("ipc0",   ipc0,             m_ipc[0]);
        chk("bus0",   bus0,             m_ipc[0]);
        chk("err0",   {63'd0, err0},    {63'd0, m_err[0]});
        chk("req1",   {63'd0, im_req1}, {63'd0, m_arr[1] && !m_tiene[1]});
        chk("dir1",   im_dir1,          m_pc[1]);
        chk("val1",   {63'd0, val1},    {63'd0, m_tiene[1]});
        chk("instr1", {32'd0, instr1},  {32'd0, m_instr[1]});
        chk("ipc1",   ipc1,             m_ipc[1]);
        chk("err1",   {63'd0, err1},    {63'd0, m_err[1]});
    endtask

    // Inputs change on the falling edge; outputs are checked just after.
    task automatic ciclo(input bit r, input bit s, input logic [63:0] d,
                         input bit a, input logic [31:0] dt, input bit l);
        rst_n = r; salto_valido = s; direccion_salto = d;
        im_ack = a; im_dato = dt; instr_listo = l;
        #1 comparar();
        @(posedge clk);
        modelo();
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] d;
        bit a;

        rst_n = 0; salto_valido = 0; direccion_salto = '0;
        im_ack = 0; im_dato = '0; instr_listo = 0;
        @(posedge clk); modelo(); @(negedge clk);

        // Reset and first sequential fetches
        ciclo(0, 0, 0, 0, 0, 0);
        chk("lit_reset_req", {63'd0, im_req0}, 64'd0);
        chk("lit_reset_val", {63'd0, val0},    64'd0);
        ciclo(1, 0, 0, 0, 0, 1);
        chk("lit_first_req", {63'd0, im_req0}, 64'd1);
        chk("lit_first_dir", im_dir0, 64'h0);
        chk("lit_hi_dir",    im_dir1, c_pc_alto);
        ciclo(1, 0, 0, 0, 0, 0);
        ciclo(1, 0, 0, 1, 32'h1111_1111, 0);
        chk("lit_instr",  {32'd0, instr0}, 64'h1111_1111);
        chk("lit_ipc",    ipc0,    64'h0);
        chk("lit_dir4",   im_dir0, 64'h4);
        chk("lit_wrap",   im_dir1, 64'h0);
        for (int i = 0; i < 5; i++) ciclo(1, 0, 0, 0, 0, 0);
        chk("lit_hold_ipc", ipc0, 64'h0);
        ciclo(1, 0, 0, 0, 0, 1);
        chk("lit_req_after_accept", {63'd0, im_req0}, 64'd1);
        ciclo(1, 0, 0, 0, 0, 0);
        ciclo(1, 0, 0, 1, 32'h2222_2222, 1);
        ciclo(1, 0, 0, 0, 0, 1);
        chk("lit_dir8", im_dir0, 64'h8);

        // Redirect while a request is outstanding
        ciclo(1, 1, 64'h100, 0, 0, 0);
        ciclo(1, 0, 0, 0, 0, 0);
        ciclo(1, 0, 0, 0, 0, 0);
        ciclo(1, 0, 0, 1, 32'hDEAD_BEEF, 0);
        chk("lit_drop_val", {63'd0, val0}, 64'd0);
        chk("lit_drop_dir", im_dir0, 64'h100);
        ciclo(1, 0, 0, 1, 32'h3333_3333, 0);
        chk("lit_tgt_ipc", ipc0, 64'h100);

        // Redirect beats a simultaneous accept
        ciclo(1, 1, 64'h200, 0, 0, 1);
        chk("lit_ent_val", {63'd0, val0}, 64'd0);
        chk("lit_ent_dir", im_dir0, 64'h200);

        // Misaligned target
        ciclo(1, 1, 64'h106, 0, 0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("lit_align_dir", im_dir0, 64'h104);
        chk("lit_align_err", {63'd0, err0}, 64'd1);
`else
        chk("lit_align_dir", im_dir0, 64'h106);
        chk("lit_align_err", {63'd0, err0}, 64'd0);
`endif
        ciclo(1, 0, 0, 1, 32'h0BAD_0BAD, 0);
        ciclo(1, 0, 0, 0, 0, 0);
        ciclo(1, 0, 0, 1, 32'h4444_4444, 0);
        ciclo(1, 0, 0, 0, 0, 1);

        // Reset mid-request, late ack ignored
        ciclo(1, 0, 0, 0, 0, 0);
        ciclo(0, 0, 0, 0, 0, 0);
        chk("lit_rst_req", {63'd0, im_req0}, 64'd0);
        chk("lit_rst_err", {63'd0, err0},    64'd0);
        ciclo(1, 0, 0, 1, 32'h5555_5555, 0);
        chk("lit_late_val", {63'd0, val0}, 64'd0);
        chk("lit_late_dir", im_dir0, 64'h0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            d = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 3) == 0) d[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) d = c_pc_alto - 64'(8 * $urandom_range(0, 3));
            a = m_arr[0] && !m_tiene[0] && ($urandom_range(0, 2) == 0);
            ciclo($urandom_range(0, 199) != 0, $urandom_range(0, 11) == 0, d,
                  a, $urandom, $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/unidad_busqueda.md
Name: unidad_busqueda

Overview:
- Instruction-fetch front end of the 64-bit core: owns the program counter, issues requests to instruction memory, and presents one fetched instruction at a time to decode.
- Consumes the branch target produced by the branch-target adder (`direccion_salto`).
- Drives `bus_direccion_im`, the address of the instruction currently being presented. That adder uses it as its base operand.

Parameters:
- ANCHO, 64, width of PC and all addresses.
- PC_RESET, 64'h0, PC value loaded at reset.
- PASO, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous reset, active-low; sampled on posedge clk.
- salto_valido  in  1  one-cycle redirect strobe from execute.
- direccion_salto  in  ANCHO  redirect target from the branch-target adder.
- im_req  out  1  instruction-memory request.
- im_dir  out  ANCHO  request address; stable while im_req=1.
- im_ack  in  1  memory completion strobe; im_dato valid in the same cycle.
- im_dato  in  32  instruction word from memory.
- instr_valida  out  1  instr/instr_pc valid to decode.
- instr  out  32  fetched instruction.
- instr_pc  out  ANCHO  address of instr.
- instr_listo  in  1  decode accepts instr this cycle.
- bus_direccion_im  out  ANCHO  equals instr_pc; base operand for the branch-target adder.
- err_alineacion  out  1  sticky misaligned-target flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc<=PC_RESET; state<=INICIO; descartar<=0.
  - im_req=0, instr_valida=0, instr=0, instr_pc=0, err_alineacion=0.
  - im_dir=pc at all times.
  - Reset wins over every other input, including in the middle of a pending request; a pending im_ack after reset is ignored.
- State INICIO: im_req=0. Next cycle goes to PEDIR.
- State PEDIR: im_req=1, im_dir=pc, held until im_ack.
  - On im_ack with descartar=0 and salto_valido=0: instr<=im_dato, instr_pc<=pc, instr_valida<=1, pc<=pc+PASO, go to ENTREGAR.
  - On im_ack with descartar=1 or salto_valido=1: data dropped, descartar<=0, stay in PEDIR. im_dir takes the new pc the next cycle; im_req stays 1, which counts as a new request.
- State ENTREGAR: im_req=0; instr, instr_pc and instr_valida hold stable.
  - On instr_listo: instr_valida<=0, go to PEDIR. Latency is 1 cycle from accept to the next im_req.
- Redirect (salto_valido=1) applies in any state: pc<=direccion_salto.
  - INICIO: go to PEDIR with the target.
  - PEDIR without im_ack: descartar<=1. The request cannot be aborted; its response is dropped.
  - PEDIR with im_ack in the same cycle: response dropped, next request to the target.
  - ENTREGAR: instr_valida<=0, go to PEDIR. The redirect overrides a simultaneous instr_listo, so the instruction counts as not accepted.
  - A second redirect before the discarded ack arrives: pc takes the latest target; only one response is dropped.
- Arithmetic: pc+PASO wraps modulo 2^ANCHO (64'hFFFF_FFFF_FFFF_FFFC+4 -> 0). No carry out.
- Throughput: one instruction per 3 cycles minimum (ack, accept, request). No prefetch.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - On a redirect with direccion_salto[1:0]!=0, pc<={direccion_salto[ANCHO-1:2],2'b00}.
  - err_alineacion<=1, sticky until reset.
- Undefined:
  - The target is used unmodified.
  - err_alineacion is tied to 0.

Test Plan:
- Reset release, im_ack 2 cycles after each request, instr_listo always 1 -> im_dir sequence 0x0, 0x4, 0x8; instr_pc matches each address; first im_req in the 2nd cycle after reset deasserts.
- instr_listo held 0 for 5 cycles while instr_valida=1 -> instr/instr_pc stable, im_req=0 throughout; request to next pc one cycle after instr_listo=1.
- salto_valido with target 0x100 while in PEDIR, ack 3 cycles later with im_dato=0xDEADBEEF -> word dropped, instr_valida stays 0, next im_dir=0x100, instr_pc=0x100 on its ack.
- salto_valido with target 0x200 in ENTREGAR, same cycle as instr_listo=1 -> instr_valida drops, next im_dir=0x200.
- PC_RESET=64'hFFFF_FFFF_FFFF_FFFC, one fetch -> next im_dir=0x0; rst_n=0 mid-PEDIR -> im_req=0 next cycle, late im_ack ignored, restart at PC_RESET.
- With FETCH_ALIGN_CHECK_EN, target 0x106 -> im_dir=0x104, err_alineacion=1 and held; without the macro -> im_dir=0x106, err_alineacion=0.
